// File: rtl/riscv_regfile_dbg_pkg.sv
// Shared constants and tap-FSM state encoding for the debug register file.
package riscv_regfile_dbg_pkg;

   localparam int unsigned XLEN_DEF = 64;
   localparam int unsigned REG_ZERO = 0;

   typedef logic [1:0] tap_state_t;

   localparam tap_state_t StRun      = 2'd0;
   localparam tap_state_t StFreezing = 2'd1;
   localparam tap_state_t StFrozen   = 2'd2;
   localparam tap_state_t StThawing  = 2'd3;

endpackage

// File: rtl/riscv_regfile_dbg_if.sv
// Register-file access, write and debug-tap signal bundle.
interface riscv_regfile_dbg_if #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned AW       = 5,
   parameter int unsigned NUM_TAPS = 5,
   parameter int unsigned CNT_W    = 32
);

   logic [AW-1:0]            rs1;
   logic [AW-1:0]            rs2;
   logic [AW-1:0]            rd;
   logic                     RegWrite;
   logic [XLEN-1:0]          WriteData;
   logic [XLEN-1:0]          ReadData1;
   logic [XLEN-1:0]          ReadData2;
   logic                     freeze_req;
   logic                     freeze_ack;
   logic [NUM_TAPS*XLEN-1:0] dbg_taps;
   logic [CNT_W-1:0]         wr_count;

   modport master (
      output rs1, rs2, rd, RegWrite, WriteData, freeze_req,
      input  ReadData1, ReadData2, freeze_ack, dbg_taps, wr_count
   );

   modport slave (
      input  rs1, rs2, rd, RegWrite, WriteData, freeze_req,
      output ReadData1, ReadData2, freeze_ack, dbg_taps, wr_count
   );

endinterface

// File: rtl/riscv_regfile_dbg_tap_ctrl.sv
// Debug-tap freeze handshake: decides when taps capture and drives freeze_ack.
module riscv_regfile_dbg_tap_ctrl
   import riscv_regfile_dbg_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic freeze_req_i,
   output logic capture_o,
   output logic freeze_ack_o
);

   tap_state_t state_q, state_d;
   logic       ack_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:      if (freeze_req_i) state_d = StFreezing;
         StFreezing: state_d = StFrozen;
         StFrozen:   if (!freeze_req_i) state_d = StThawing;
         StThawing:  state_d = StRun;
         default:    state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StRun;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= (state_d == StFrozen);
      end
   end

   // FREEZING and THAWING both take one more snapshot; only FROZEN holds.
   assign capture_o    = (state_q != StFrozen);
   assign freeze_ack_o = ack_q;

endmodule

// File: rtl/riscv_regfile_dbg.sv
// Register file with async bypassed reads, sync write, x0 tied to zero, freezable debug taps
// and a saturating write counter.
module riscv_regfile_dbg
   import riscv_regfile_dbg_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned AW       = $clog2(NREGS),
   parameter int unsigned NUM_TAPS = 5,
   parameter int unsigned TAP_BASE = 0,
   parameter int unsigned CNT_W    = 32
) (
   input logic               clk,
   input logic               reset,
   riscv_regfile_dbg_if.slave bus
);

   logic [XLEN-1:0]          regs_q [NREGS];
   logic [XLEN-1:0]          regs_d [NREGS];
   logic [NUM_TAPS*XLEN-1:0] taps_q, taps_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     wr_en;
   logic                     capture;

   assign wr_en = bus.RegWrite && (bus.rd != AW'(REG_ZERO));

   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[bus.rd] = bus.WriteData;
   end

   always_comb begin
      bus.ReadData1 = regs_q[bus.rs1];
      bus.ReadData2 = regs_q[bus.rs2];
      if (bus.RegWrite && bus.rd == bus.rs1) bus.ReadData1 = bus.WriteData;
      if (bus.RegWrite && bus.rd == bus.rs2) bus.ReadData2 = bus.WriteData;
      if (bus.rs1 == AW'(REG_ZERO)) bus.ReadData1 = '0;
      if (bus.rs2 == AW'(REG_ZERO)) bus.ReadData2 = '0;
   end

   // Taps mirror post-write values so a tap matches its register one cycle after the write.
   always_comb begin
      taps_d = taps_q;
      if (capture) begin
         for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            taps_d[k*XLEN +: XLEN] = regs_d[AW'(TAP_BASE + k)];
         end
      end
   end

   assign cnt_d = (wr_en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
         taps_q <= '0;
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         taps_q <= taps_d;
         cnt_q  <= cnt_d;
      end
   end

   riscv_regfile_dbg_tap_ctrl u_tap_ctrl (
      .clk          (clk),
      .reset        (reset),
      .freeze_req_i (bus.freeze_req),
      .capture_o    (capture),
      .freeze_ack_o (bus.freeze_ack)
   );

   assign bus.dbg_taps = taps_q;
   assign bus.wr_count = cnt_q;

endmodule

// File: tb/tb_riscv_regfile_dbg.sv
// Directed vector table plus freeze/reset/saturation sequences and a randomised model compare.
module tb_riscv_regfile_dbg;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned NTAPS = 5;
   localparam int unsigned CNTW  = 4;

   typedef struct {
      logic            we;
      logic [4:0]      rd;
      logic [XLEN-1:0] wd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] exp1;
      logic [XLEN-1:0] exp2;
      logic [CNTW-1:0] exp_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [XLEN-1:0] m_regs [32];
   logic [CNTW-1:0] m_cnt;

   always #5 clk = ~clk;

   riscv_regfile_dbg_if #(.XLEN(XLEN), .AW(5), .NUM_TAPS(NTAPS), .CNT_W(CNTW)) bus ();

   riscv_regfile_dbg #(.XLEN(XLEN), .NREGS(32), .NUM_TAPS(NTAPS), .TAP_BASE(0), .CNT_W(CNTW))
   dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] rd, input logic [XLEN-1:0] wd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
      bus.RegWrite  = we;
      bus.rd        = rd;
      bus.WriteData = wd;
      bus.rs1       = rs1;
      bus.rs2       = rs2;
   endtask

   function automatic logic [XLEN-1:0] tap(input int k);
      return bus.dbg_taps[k*XLEN +: XLEN];
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   vec_t vecs [7];

   initial begin
      vecs[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF, 5'd5,  5'd0,  64'hDEAD_BEEF, 64'h0, 4'd1};
      vecs[1] = '{1'b0, 5'd5,  64'h0,         5'd5,  5'd5,  64'hDEAD_BEEF, 64'hDEAD_BEEF, 4'd1};
      vecs[2] = '{1'b1, 5'd0,  64'h1234,      5'd0,  5'd5,  64'h0, 64'hDEAD_BEEF, 4'd1};
      vecs[3] = '{1'b1, 5'd7,  64'hA5A5,      5'd7,  5'd7,  64'hA5A5, 64'hA5A5, 4'd2};
      vecs[4] = '{1'b1, 5'd31, {64{1'b1}},    5'd31, 5'd7,  {64{1'b1}}, 64'hA5A5, 4'd3};
      vecs[5] = '{1'b0, 5'd31, 64'h5555,      5'd31, 5'd6,  {64{1'b1}}, 64'h0, 4'd3};
      vecs[6] = '{1'b1, 5'd5,  64'h1,         5'd5,  5'd7,  64'h1, 64'hA5A5, 4'd4};

      bus.freeze_req = 1'b0;
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
      reset = 1'b0;
      #2;
      do_reset();

      // Reset state: every index reads zero, outputs cleared.
      for (int i = 0; i < 32; i++) begin
         bus.rs1 = 5'(i);
         bus.rs2 = 5'(31 - i);
         #1;
         chk("rst_rd1", bus.ReadData1, '0);
         chk("rst_rd2", bus.ReadData2, '0);
      end
      chk("rst_cnt", 64'(bus.wr_count), 64'd0);
      chk("rst_ack", 64'(bus.freeze_ack), 64'd0);
      for (int k = 0; k < NTAPS; k++) chk("rst_tap", tap(k), '0);

      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].rs1, vecs[i].rs2);
         #1;
         chk("vec_rd1", bus.ReadData1, vecs[i].exp1);
         chk("vec_rd2", bus.ReadData2, vecs[i].exp2);
         tick();
         chk("vec_cnt", 64'(bus.wr_count), 64'(vecs[i].exp_cnt));
         chk("vec_tap0", tap(0), '0);
      end

      // Freeze handshake with a write while frozen.
      drive(1'b1, 5'd1, 64'd10, 5'd1, 5'd0);
      bus.freeze_req = 1'b1;
      tick();
      drive(1'b0, 5'd0, '0, 5'd1, 5'd0);
      chk("frz_ack_early", 64'(bus.freeze_ack), 64'd0);
      chk("frz_tap1_a", tap(1), 64'd10);
      tick();
      chk("frz_ack_hi", 64'(bus.freeze_ack), 64'd1);
      chk("frz_tap1_b", tap(1), 64'd10);
      drive(1'b1, 5'd1, 64'd20, 5'd1, 5'd0);
      #1;
      chk("frz_bypass", bus.ReadData1, 64'd20);
      tick();
      drive(1'b0, 5'd0, '0, 5'd1, 5'd0);
      #1;
      chk("frz_tap1_hold", tap(1), 64'd10);
      chk("frz_rd_x1", bus.ReadData1, 64'd20);
      chk("frz_cnt", 64'(bus.wr_count), 64'd6);
      tick();
      chk("frz_tap1_hold2", tap(1), 64'd10);
      bus.freeze_req = 1'b0;
      tick();
      chk("thaw_ack_lo", 64'(bus.freeze_ack), 64'd0);
      chk("thaw_tap1_a", tap(1), 64'd10);
      tick();
      chk("thaw_tap1_b", tap(1), 64'd20);

      // Request dropped during FREEZING still passes through FROZEN.
      bus.freeze_req = 1'b1;
      tick();
      bus.freeze_req = 1'b0;
      tick();
      chk("short_ack_hi", 64'(bus.freeze_ack), 64'd1);
      tick();
      chk("short_ack_lo", 64'(bus.freeze_ack), 64'd0);
      tick();

      // Reset while frozen.
      drive(1'b1, 5'd3, 64'd7, 5'd3, 5'd0);
      bus.freeze_req = 1'b1;
      tick();
      drive(1'b0, 5'd0, '0, 5'd3, 5'd0);
      tick();
      chk("pre_rst_ack", 64'(bus.freeze_ack), 64'd1);
      chk("pre_rst_tap3", tap(3), 64'd7);
      bus.freeze_req = 1'b0;
      do_reset();
      chk("mid_rst_ack", 64'(bus.freeze_ack), 64'd0);
      chk("mid_rst_x3", bus.ReadData1, 64'd0);
      chk("mid_rst_cnt", 64'(bus.wr_count), 64'd0);
      for (int k = 0; k < NTAPS; k++) chk("mid_rst_tap", tap(k), '0);
      drive(1'b1, 5'd2, 64'd9, 5'd0, 5'd0);
      tick();
      chk("run_tap2", tap(2), 64'd9);

      // Saturation: 16 writes from zero stop at 15.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 5'd4, 64'(i + 1), 5'd4, 5'd0);
         tick();
         chk("sat_cnt", 64'(bus.wr_count), 64'((i + 1 > 15) ? 15 : i + 1));
      end
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
      chk("sat_tap4", tap(4), 64'd16);

      // Randomised compare against a reference model.
      do_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
      for (int c = 0; c < 10000; c++) begin
         logic            we;
         logic [4:0]      rd, r1, r2;
         logic [XLEN-1:0] wd, e1, e2;
         we = 1'($urandom_range(0, 1));
         rd = 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         r2 = 5'($urandom_range(0, 31));
         wd = {$urandom, $urandom};
         drive(we, rd, wd, r1, r2);
         e1 = (r1 == 0) ? '0 : (we && rd == r1) ? wd : m_regs[r1];
         e2 = (r2 == 0) ? '0 : (we && rd == r2) ? wd : m_regs[r2];
         #1;
         chk("rnd_rd1", bus.ReadData1, e1);
         chk("rnd_rd2", bus.ReadData2, e2);
         tick();
         if (we && rd != 0) begin
            m_regs[rd] = wd;
            if (m_cnt != 4'hF) m_cnt = m_cnt + 1'b1;
         end
         chk("rnd_cnt", 64'(bus.wr_count), 64'(m_cnt));
         chk("rnd_tap", tap(c % NTAPS), m_regs[c % NTAPS]);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
